// File: rtl/bus_cycle_initiator.sv
`default_nettype none
// ============================================================================
// Module   : bus_cycle_initiator
// Brief    : Multiplexed address/data bus-cycle master (T1-T2-T3-[TW]-T4).
//            Optional READY timeout enabled by macro BUS_WAIT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_cycle_initiator #(
    parameter int ADDR_WIDTH     = 20,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic                           req_io,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [DATA_WIDTH-1:0]          req_wdata,
    output logic                           rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    inout  wire  [DATA_WIDTH-1:0]          AD,
    output logic [ADDR_WIDTH-DATA_WIDTH-1:0] A_HI,
    output logic                           ALE,
    output logic                           RD_n,
    output logic                           WR_n,
    output logic                           IOM,
    output logic                           DEN_n,
    output logic                           DT_R,
    input  logic                           READY
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_TW   = 3'd4,
        S_T4   = 3'd5
    } state_t;

    state_t                  r_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]   r_addr_q,  w_addr_d;
    logic [DATA_WIDTH-1:0]   r_wdata_q, w_wdata_d;
    logic [DATA_WIDTH-1:0]   r_rdata_q, w_rdata_d;
    logic                    r_write_q, w_write_d;
    logic                    r_io_q,    w_io_d;
    logic                    r_err_q,   w_err_d;

`ifdef BUS_WAIT_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0]      r_wait_cnt_q, w_wait_cnt_d;
`else
    logic                    w_unused;
    assign w_unused = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q    <= S_IDLE;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_rdata_q    <= '0;
            r_write_q    <= 1'b0;
            r_io_q       <= 1'b0;
            r_err_q      <= 1'b0;
`ifdef BUS_WAIT_TIMEOUT_EN
            r_wait_cnt_q <= '0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_rdata_q    <= w_rdata_d;
            r_write_q    <= w_write_d;
            r_io_q       <= w_io_d;
            r_err_q      <= w_err_d;
`ifdef BUS_WAIT_TIMEOUT_EN
            r_wait_cnt_q <= w_wait_cnt_d;
`endif
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_rdata_d = r_rdata_q;
        w_write_d = r_write_q;
        w_io_d    = r_io_q;
        w_err_d   = r_err_q;
`ifdef BUS_WAIT_TIMEOUT_EN
        w_wait_cnt_d = r_wait_cnt_q;
`endif
        case (r_state_q)
            S_IDLE: begin
                if (req_valid) begin
                    w_addr_d  = req_addr;
                    w_wdata_d = req_wdata;
                    w_write_d = req_write;
                    w_io_d    = req_io;
                    w_state_d = S_T1;
                end
            end
            S_T1: begin
                w_err_d   = 1'b0;
`ifdef BUS_WAIT_TIMEOUT_EN
                w_wait_cnt_d = '0;
`endif
                w_state_d = S_T2;
            end
            S_T2: w_state_d = S_T3;
            S_T3, S_TW: begin
                if (READY) begin
                    // Read data is sampled on the edge that enters T4.
                    if (!r_write_q) begin
                        w_rdata_d = AD;
                    end
                    w_state_d = S_T4;
`ifdef BUS_WAIT_TIMEOUT_EN
                end else if ((r_state_q == S_TW) &&
                             (r_wait_cnt_q == c_CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    w_err_d   = 1'b1;
                    w_rdata_d = '0;
                    w_state_d = S_T4;
                end else begin
                    if (r_state_q == S_TW) begin
                        w_wait_cnt_d = r_wait_cnt_q + 1'b1;
                    end
                    w_state_d = S_TW;
`else
                end else begin
                    w_state_d = S_TW;
`endif
                end
            end
            S_T4:    w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    logic w_data_phase;
    logic w_strobe;
    logic w_ad_oe;
    logic [DATA_WIDTH-1:0] w_ad_out;

    // All bus outputs fall back to their idle levels while RESET is held.
    assign w_data_phase = !RESET && ((r_state_q == S_T2) || (r_state_q == S_T3) ||
                                     (r_state_q == S_TW) || (r_state_q == S_T4));
    assign w_strobe     = !RESET && ((r_state_q == S_T2) || (r_state_q == S_T3) ||
                                     (r_state_q == S_TW));

    assign req_ready = !RESET && (r_state_q == S_IDLE);
    assign ALE       = !RESET && (r_state_q == S_T1);
    assign RD_n      = !(w_strobe && !r_write_q);
    assign WR_n      = !(w_strobe && r_write_q);
    assign DEN_n     = !w_data_phase;
    assign IOM       = !RESET && r_io_q;
    assign DT_R      = !RESET && r_write_q;
    assign A_HI      = RESET ? '0 : r_addr_q[ADDR_WIDTH-1:DATA_WIDTH];
    assign rsp_valid = !RESET && (r_state_q == S_T4);
    assign rsp_rdata = RESET ? '0 : r_rdata_q;

`ifdef BUS_WAIT_TIMEOUT_EN
    assign rsp_err   = rsp_valid && r_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

    assign w_ad_oe  = ALE || (w_data_phase && r_write_q);
    assign w_ad_out = ALE ? r_addr_q[DATA_WIDTH-1:0] : r_wdata_q;
    assign AD       = w_ad_oe ? w_ad_out : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_cycle_initiator
// Brief    : Directed self-checking bench for bus_cycle_initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_initiator;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid, req_ready, req_write, req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    wire  [7:0]  AD;
    logic [11:0] A_HI;
    logic        ALE, RD_n, WR_n, IOM, DEN_n, DT_R, READY;

    logic        tb_ad_oe;
    logic [7:0]  tb_ad;
    assign AD = tb_ad_oe ? tb_ad : 8'bz;

    int n_checks = 0;
    int n_pass   = 0;
    int n;

    bus_cycle_initiator #(
        .ADDR_WIDTH    (20),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(4)
    ) u_dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_io   (req_io),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .AD       (AD),
        .A_HI     (A_HI),
        .ALE      (ALE),
        .RD_n     (RD_n),
        .WR_n     (WR_n),
        .IOM      (IOM),
        .DEN_n    (DEN_n),
        .DT_R     (DT_R),
        .READY    (READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic io, input logic [19:0] a,
                         input logic [7:0] d);
        req_write = wr;
        req_io    = io;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
    endtask

    initial begin
        RESET = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0;
        req_addr = '0; req_wdata = '0; READY = 1'b1; tb_ad_oe = 1'b0; tb_ad = '0;
        step(); step();
        chk("rst_ready", req_ready, 0);
        chk("rst_ale",   ALE, 0);
        chk("rst_strb",  {RD_n, WR_n, DEN_n}, 3'b111);
        chk("rst_dtr_iom", {DT_R, IOM}, 2'b00);
        chk("rst_ahi",   A_HI, 0);
        chk("rst_rsp",   {rsp_valid, rsp_err}, 2'b00);
        chk("rst_rdata", rsp_rdata, 0);
        RESET = 1'b0; req_valid = 1'b0;
        #1 chk("idle_ready", req_ready, 1);

        // Zero-wait memory read at 0x12345
        issue(1'b0, 1'b0, 20'h12345, 8'h00);
        #1 chk("rd_accept_ready", req_ready, 1);
        step(); req_valid = 1'b0;
        chk("rd_t1_ale",  ALE, 1);
        chk("rd_t1_ad",   AD, 8'h45);
        chk("rd_t1_ahi",  A_HI, 12'h123);
        chk("rd_t1_ctl",  {IOM, DT_R, RD_n, DEN_n}, 4'b0011);
        tb_ad_oe = 1'b1; tb_ad = 8'h11;
        step();
        chk("rd_t2_ctl",  {ALE, RD_n, WR_n, DEN_n, rsp_valid}, 5'b00100);
        chk("rd_t2_ahi",  A_HI, 12'h123);
        tb_ad = 8'h5A;
        step();
        chk("rd_t3_ctl",  {RD_n, rsp_valid}, 2'b00);
        step();
        chk("rd_t4_ctl",  {rsp_valid, rsp_err, RD_n, WR_n, DEN_n}, 5'b10110);
        chk("rd_t4_data", rsp_rdata, 8'h5A);
        tb_ad_oe = 1'b0;
        step();
        chk("rd_idle",    {rsp_valid, req_ready}, 2'b01);
        chk("rd_hold",    rsp_rdata, 8'h5A);

        // I/O write of 0xA5 to 0x003F8
        issue(1'b1, 1'b1, 20'h003F8, 8'hA5);
        step(); req_valid = 1'b0;
        chk("wr_t1_ale",  ALE, 1);
        chk("wr_t1_ad",   AD, 8'hF8);
        chk("wr_t1_ahi",  A_HI, 12'h003);
        chk("wr_t1_ctl",  {IOM, DT_R, WR_n}, 3'b111);
        step();
        chk("wr_t2_ctl",  {ALE, WR_n, RD_n, DEN_n}, 4'b0010);
        chk("wr_t2_ad",   AD, 8'hA5);
        step();
        chk("wr_t3_wr",   WR_n, 0);
        chk("wr_t3_ad",   AD, 8'hA5);
        step();
        chk("wr_t4_ctl",  {rsp_valid, rsp_err, WR_n, IOM, DT_R}, 5'b10111);
        chk("wr_t4_ad",   AD, 8'hA5);
        chk("wr_rdata_kept", rsp_rdata, 8'h5A);
        step();

        // Read with three wait states
        issue(1'b0, 1'b0, 20'h00100, 8'h00);
        READY = 1'b0;
        step(); req_valid = 1'b0;
        tb_ad_oe = 1'b1; tb_ad = 8'h77;
        n = 1;
        while (!rsp_valid && n < 40) begin
            if (n == 5) chk("tw_rd_low", {RD_n, DEN_n}, 2'b00);
            if (n == 6) begin READY = 1'b1; tb_ad = 8'h3C; end
            step(); n++;
        end
        chk("tw_total_clks", n, 7);
        chk("tw_rdata",      rsp_rdata, 8'h3C);
        tb_ad_oe = 1'b0;
        step();

        // Reset in the middle of a wait state
        issue(1'b0, 1'b0, 20'h00200, 8'h00);
        READY = 1'b0;
        step(); req_valid = 1'b0;
        step(); step(); step(); step();
        RESET = 1'b1;
        #1 chk("mid_rst_out", {RD_n, req_ready, rsp_valid}, 3'b100);
        step(); RESET = 1'b0;
        #1 chk("post_rst_idle", {req_ready, rsp_valid, RD_n, WR_n, DEN_n, ALE}, 6'b101110);
        chk("post_rst_rdata", rsp_rdata, 0);
        step();
        chk("post_rst_no_rsp", rsp_valid, 0);
        READY = 1'b1;
        issue(1'b1, 1'b1, 20'h00055, 8'h3C);
        step(); req_valid = 1'b0;
        chk("post_rst_t1", {ALE, AD}, {1'b1, 8'h55});
        step(); step(); step();
        chk("post_rst_rsp", rsp_valid, 1);
        step();

        // READY stuck low
        issue(1'b0, 1'b0, 20'h00300, 8'h00);
        READY = 1'b0;
        step(); req_valid = 1'b0;
        tb_ad_oe = 1'b1; tb_ad = 8'hEE;
        n = 1;
        while (!rsp_valid && n < 30) begin
            step(); n++;
        end
`ifdef BUS_WAIT_TIMEOUT_EN
        chk("to_clks",  n, 8);
        chk("to_err",   {rsp_valid, rsp_err}, 2'b11);
        chk("to_rdata", rsp_rdata, 0);
        step();
`else
        chk("stuck_no_rsp", rsp_valid, 0);
        chk("stuck_rd_low", RD_n, 0);
        RESET = 1'b1; step(); RESET = 1'b0; #1;
`endif
        tb_ad_oe = 1'b0;
        READY = 1'b1;

        // Back-to-back requests with req_valid held high
        issue(1'b1, 1'b0, 20'h00400, 8'h99);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("b2b_ready", req_ready, (i % 5 == 0));
            chk("b2b_rsp",   rsp_valid, (i % 5 == 4));
        end
        req_valid = 1'b0;
        step(); step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
